fragment_depth_test: RTL and testbench

FRAGMENT_DEPTH_TEST -- requirements
Module: fragment_depth_test

---
 rtl/RegisterAndDescriptorDefines.sv | 34 +++
 rtl/fragment_depth_fifo.sv | 45 ++++
 rtl/fragment_depth_test.sv | 138 +++++++++++++
 tb/tb_fragment_depth_test.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/RegisterAndDescriptorDefines.sv
// RegisterAndDescriptorDefines: shared depth-function encodings, saturation constant and depth helpers
package RegisterAndDescriptorDefines;

   typedef enum logic [2:0] {
      DF_NEVER    = 3'd0,
      DF_LESS     = 3'd1,
      DF_EQUAL    = 3'd2,
      DF_LEQUAL   = 3'd3,
      DF_GREATER  = 3'd4,
      DF_NOTEQUAL = 3'd5,
      DF_GEQUAL   = 3'd6,
      DF_ALWAYS   = 3'd7
   } depth_func_e;

   localparam logic [15:0] DEPTH_SAT = 16'hFFFF;

   function automatic logic [15:0] sat_depth(input logic [31:0] d);
      return (d[31:16] != 16'd0) ? DEPTH_SAT : d[15:0];
   endfunction

   function automatic logic depth_pass(input depth_func_e f, input logic [15:0] frag, input logic [15:0] stored);
      case (f)
         DF_NEVER:    return 1'b0;
         DF_LESS:     return frag < stored;
         DF_EQUAL:    return frag == stored;
         DF_LEQUAL:   return frag <= stored;
         DF_GREATER:  return frag > stored;
         DF_NOTEQUAL: return frag != stored;
         DF_GEQUAL:   return frag >= stored;
         default:     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/fragment_depth_fifo.sv
// fragment_depth_fifo: small synchronous FIFO holding depth-tested fragments
module fragment_depth_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
)(
   input  logic             aclk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;

   assign empty = count == '0;
   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // storage array, no reset needed since occupancy gates what is visible
   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge aclk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fragment_depth_test.sv
// fragment_depth_test: pipelined depth test between a fragment stream and an external depth buffer
module fragment_depth_test
   import RegisterAndDescriptorDefines::*;
#(
   parameter int INDEX_WIDTH = 14,
   parameter int SCREEN_POS_WIDTH = 11,
   parameter int PIXEL_WIDTH = 32,
   parameter int DEPTH_WIDTH = 16,
   parameter int READ_LATENCY = 2
)(
   input  logic                        aclk,
   input  logic                        reset,
   input  logic                        confEnable,
   input  logic [2:0]                  confDepthFunc,
   input  logic                        confDepthMask,
   input  logic                        s_frag_tvalid,
   output logic                        s_frag_tready,
   input  logic                        s_frag_tlast,
   input  logic                        s_frag_tkeep,
   input  logic [INDEX_WIDTH-1:0]      s_frag_tindex,
   input  logic [SCREEN_POS_WIDTH-1:0] s_frag_tscreenPosX,
   input  logic [SCREEN_POS_WIDTH-1:0] s_frag_tscreenPosY,
   input  logic [31:0]                 s_frag_tdepth,
   input  logic [PIXEL_WIDTH-1:0]      s_frag_tfragmentColor,
   output logic                        depthRdEn,
   output logic [INDEX_WIDTH-1:0]      depthRdAddr,
   input  logic [DEPTH_WIDTH-1:0]      depthRdData,
   output logic                        depthWrEn,
   output logic [INDEX_WIDTH-1:0]      depthWrAddr,
   output logic [DEPTH_WIDTH-1:0]      depthWrData,
   output logic                        m_frag_tvalid,
   input  logic                        m_frag_tready,
   output logic                        m_frag_tlast,
   output logic                        m_frag_tkeep,
   output logic [INDEX_WIDTH-1:0]      m_frag_tindex,
   output logic [SCREEN_POS_WIDTH-1:0] m_frag_tscreenPosX,
   output logic [SCREEN_POS_WIDTH-1:0] m_frag_tscreenPosY,
   output logic [PIXEL_WIDTH-1:0]      m_frag_tfragmentColor
);

   localparam int FIFO_DEPTH = READ_LATENCY + 2;
   localparam int PW = 2 + INDEX_WIDTH + 2 * SCREEN_POS_WIDTH + PIXEL_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [READ_LATENCY:1] p_valid, p_keep, p_last, p_test;
   logic [INDEX_WIDTH-1:0] p_index [1:READ_LATENCY];
   logic [SCREEN_POS_WIDTH-1:0] p_x [1:READ_LATENCY];
   logic [SCREEN_POS_WIDTH-1:0] p_y [1:READ_LATENCY];
   logic [PIXEL_WIDTH-1:0] p_color [1:READ_LATENCY];
   logic [DEPTH_WIDTH-1:0] p_depth [1:READ_LATENCY];
   logic wr_en;
   logic [INDEX_WIDTH-1:0] wr_addr;
   logic [DEPTH_WIDTH-1:0] wr_data;
   logic accept, hazard, credit_ok, pass, fifo_pop, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [PW-1:0] fifo_in, fifo_out;
   logic [DEPTH_WIDTH-1:0] frag_depth;

   // an index with a write still outstanding must not be read again until that write lands
   always_comb begin
      hazard = wr_en && (wr_addr == s_frag_tindex);
      for (int k = 1; k <= READ_LATENCY; k++)
         hazard = hazard || (p_valid[k] && p_test[k] && confDepthMask && (p_index[k] == s_frag_tindex));
   end

   assign credit_ok = (int'(fifo_count) + $countones(p_valid)) < FIFO_DEPTH;
   assign s_frag_tready = !reset && credit_ok && !hazard;
   assign accept = s_frag_tvalid && s_frag_tready;
   assign frag_depth = DEPTH_WIDTH'(sat_depth(s_frag_tdepth));

   assign depthRdEn = accept && confEnable && s_frag_tkeep;
   assign depthRdAddr = s_frag_tindex;

   assign pass = !p_test[READ_LATENCY] ||
                 depth_pass(depth_func_e'(confDepthFunc), 16'(p_depth[READ_LATENCY]), 16'(depthRdData));

   assign depthWrEn = wr_en && !reset;
   assign depthWrAddr = wr_addr;
   assign depthWrData = wr_data;

   // fragment valids and the write strobe; clearing them on reset drops all in-flight work
   always_ff @(posedge aclk) begin
      if (reset) begin
         p_valid <= '0;
         wr_en <= 1'b0;
      end else begin
         p_valid[1] <= accept;
         for (int k = 2; k <= READ_LATENCY; k++) p_valid[k] <= p_valid[k-1];
         wr_en <= p_valid[READ_LATENCY] && p_test[READ_LATENCY] && confDepthMask && pass;
      end
   end

   // fragment payload travels alongside the depth buffer read
   always_ff @(posedge aclk) begin
      p_keep[1] <= s_frag_tkeep;
      p_last[1] <= s_frag_tlast;
      p_test[1] <= confEnable && s_frag_tkeep;
      p_index[1] <= s_frag_tindex;
      p_x[1] <= s_frag_tscreenPosX;
      p_y[1] <= s_frag_tscreenPosY;
      p_color[1] <= s_frag_tfragmentColor;
      p_depth[1] <= frag_depth;
      for (int k = 2; k <= READ_LATENCY; k++) begin
         p_keep[k] <= p_keep[k-1];
         p_last[k] <= p_last[k-1];
         p_test[k] <= p_test[k-1];
         p_index[k] <= p_index[k-1];
         p_x[k] <= p_x[k-1];
         p_y[k] <= p_y[k-1];
         p_color[k] <= p_color[k-1];
         p_depth[k] <= p_depth[k-1];
      end
      wr_addr <= p_index[READ_LATENCY];
      wr_data <= p_depth[READ_LATENCY];
   end

   assign fifo_in = {p_last[READ_LATENCY], p_keep[READ_LATENCY] && pass, p_index[READ_LATENCY],
                     p_x[READ_LATENCY], p_y[READ_LATENCY], p_color[READ_LATENCY]};
   assign m_frag_tvalid = !fifo_empty && !reset;
   assign fifo_pop = m_frag_tvalid && m_frag_tready;
   assign {m_frag_tlast, m_frag_tkeep, m_frag_tindex, m_frag_tscreenPosX, m_frag_tscreenPosY,
           m_frag_tfragmentColor} = fifo_out;

   fragment_depth_fifo #(
      .WIDTH(PW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .aclk(aclk),
      .reset(reset),
      .push(p_valid[READ_LATENCY]),
      .push_data(fifo_in),
      .pop(fifo_pop),
      .pop_data(fifo_out),
      .count(fifo_count),
      .empty(fifo_empty)
   );

endmodule

// File: tb/tb_fragment_depth_test.sv
// tb_fragment_depth_test: scoreboard bench for fragment_depth_test with a behavioural depth buffer
module tb_fragment_depth_test;

   localparam int RL = 2;

   typedef struct { logic [69:0] pl; int acc; bit lat; } out_t;
   typedef struct { logic [29:0] aw; int cyc; } wr_t;

   logic aclk = 1'b0;
   logic reset = 1'b1;
   logic confEnable, confDepthMask;
   logic [2:0] confDepthFunc;
   logic s_frag_tvalid, s_frag_tready, s_frag_tlast, s_frag_tkeep;
   logic [13:0] s_frag_tindex;
   logic [10:0] s_frag_tscreenPosX, s_frag_tscreenPosY;
   logic [31:0] s_frag_tdepth, s_frag_tfragmentColor;
   logic depthRdEn, depthWrEn;
   logic [13:0] depthRdAddr, depthWrAddr;
   logic [15:0] depthRdData, depthWrData;
   logic m_frag_tvalid, m_frag_tready, m_frag_tlast, m_frag_tkeep;
   logic [13:0] m_frag_tindex;
   logic [10:0] m_frag_tscreenPosX, m_frag_tscreenPosY;
   logic [31:0] m_frag_tfragmentColor;

   logic [15:0] bmem [16384];
   logic [15:0] rmem [16384];
   logic [15:0] rd_pipe [RL];
   out_t oq[$];
   wr_t wq[$];
   out_t e;
   wr_t w;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   bit lat_mode = 1'b1;
   bit rnd_ready = 1'b0;
   bit stall_prev = 1'b0;
   logic [69:0] prev_pl;

   always #5 aclk = ~aclk;

   fragment_depth_test dut (
      .aclk(aclk), .reset(reset),
      .confEnable(confEnable), .confDepthFunc(confDepthFunc), .confDepthMask(confDepthMask),
      .s_frag_tvalid(s_frag_tvalid), .s_frag_tready(s_frag_tready), .s_frag_tlast(s_frag_tlast),
      .s_frag_tkeep(s_frag_tkeep), .s_frag_tindex(s_frag_tindex),
      .s_frag_tscreenPosX(s_frag_tscreenPosX), .s_frag_tscreenPosY(s_frag_tscreenPosY),
      .s_frag_tdepth(s_frag_tdepth), .s_frag_tfragmentColor(s_frag_tfragmentColor),
      .depthRdEn(depthRdEn), .depthRdAddr(depthRdAddr), .depthRdData(depthRdData),
      .depthWrEn(depthWrEn), .depthWrAddr(depthWrAddr), .depthWrData(depthWrData),
      .m_frag_tvalid(m_frag_tvalid), .m_frag_tready(m_frag_tready), .m_frag_tlast(m_frag_tlast),
      .m_frag_tkeep(m_frag_tkeep), .m_frag_tindex(m_frag_tindex),
      .m_frag_tscreenPosX(m_frag_tscreenPosX), .m_frag_tscreenPosY(m_frag_tscreenPosY),
      .m_frag_tfragmentColor(m_frag_tfragmentColor)
   );

   // depth buffer with a fixed read latency
   always @(posedge aclk) begin
      rd_pipe[0] <= depthRdEn ? bmem[depthRdAddr] : 16'hDEAD;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (depthWrEn) bmem[depthWrAddr] <= depthWrData;
   end
   assign depthRdData = rd_pipe[RL-1];

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit ref_cmp(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
      case (f)
         3'd0: return 1'b0;
         3'd1: return a < b;
         3'd2: return a == b;
         3'd3: return a <= b;
         3'd4: return a > b;
         3'd5: return a != b;
         3'd6: return a >= b;
         default: return 1'b1;
      endcase
   endfunction

   // predict output and depth write for the fragment currently being accepted
   task automatic predict();
      logic [15:0] conv;
      logic test, pass;
      conv = (s_frag_tdepth[31:16] != 16'd0) ? 16'hFFFF : s_frag_tdepth[15:0];
      test = confEnable && s_frag_tkeep;
      pass = !test || ref_cmp(confDepthFunc, conv, rmem[s_frag_tindex]);
      oq.push_back('{pl: {s_frag_tlast, s_frag_tkeep && pass, s_frag_tindex, s_frag_tscreenPosX,
                          s_frag_tscreenPosY, s_frag_tfragmentColor}, acc: cyc, lat: lat_mode});
      if (test && confDepthMask && pass) begin
         rmem[s_frag_tindex] = conv;
         wq.push_back('{aw: {s_frag_tindex, conv}, cyc: cyc + RL + 1});
      end
   endtask

   task automatic drive(input logic [13:0] idx, input logic [31:0] dep, input logic keep, input logic last);
      s_frag_tvalid = 1'b1;
      s_frag_tindex = idx;
      s_frag_tdepth = dep;
      s_frag_tkeep = keep;
      s_frag_tlast = last;
      s_frag_tscreenPosX = 11'($urandom);
      s_frag_tscreenPosY = 11'($urandom);
      s_frag_tfragmentColor = $urandom;
   endtask

   task automatic send(input logic [13:0] idx, input logic [31:0] dep, input logic keep, input logic last,
                       output int acc);
      int waited = 0;
      if (rnd_ready) m_frag_tready = ($urandom_range(0, 3) != 0);
      drive(idx, dep, keep, last);
      @(negedge aclk);
      while (!s_frag_tready && waited < 60) begin
         @(posedge aclk);
         #1;
         if (rnd_ready) m_frag_tready = 1'b1;
         waited++;
         @(negedge aclk);
      end
      chk("accept", s_frag_tready, 1'b1);
      acc = -1;
      if (s_frag_tready) begin
         predict();
         acc = cyc;
      end
      @(posedge aclk);
      #1;
      s_frag_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      m_frag_tready = 1'b1;
      while ((oq.size() != 0 || wq.size() != 0) && n < 200) begin
         @(posedge aclk);
         n++;
      end
      chk("drain", oq.size() + wq.size(), 0);
      repeat (2) @(posedge aclk);
      #1;
   endtask

   // output, write-port and reset monitor
   always @(negedge aclk) begin
      if (reset) begin
         chk("reset_outs", {s_frag_tready, m_frag_tvalid, depthRdEn, depthWrEn}, 4'b0);
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_stable", {m_frag_tvalid, m_frag_tlast, m_frag_tkeep, m_frag_tindex, m_frag_tscreenPosX,
                                 m_frag_tscreenPosY, m_frag_tfragmentColor}, {1'b1, prev_pl});
         prev_pl = {m_frag_tlast, m_frag_tkeep, m_frag_tindex, m_frag_tscreenPosX, m_frag_tscreenPosY,
                    m_frag_tfragmentColor};
         stall_prev = m_frag_tvalid && !m_frag_tready;
         if (m_frag_tvalid && m_frag_tready) begin
            if (oq.size() == 0) chk("unexpected_out", m_frag_tvalid, 1'b0);
            else begin
               e = oq.pop_front();
               chk("out_payload", prev_pl, e.pl);
               if (e.lat) chk("out_latency", cyc - e.acc, RL + 1);
            end
         end
         if (depthWrEn) begin
            if (wq.size() == 0) chk("unexpected_wr", depthWrEn, 1'b0);
            else begin
               w = wq.pop_front();
               chk("wr_addr_data", {depthWrAddr, depthWrData}, w.aw);
               chk("wr_cycle", cyc, w.cyc);
            end
         end
         if (!confEnable) chk("rd_wr_disabled", {depthRdEn, depthWrEn}, 2'b0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, prev, k;
      for (int i = 0; i < 16384; i++) begin
         bmem[i] = 16'h8000;
         rmem[i] = 16'h8000;
      end
      confEnable = 1'b1;
      confDepthFunc = 3'd1;
      confDepthMask = 1'b1;
      m_frag_tready = 1'b1;
      s_frag_tvalid = 1'b0;
      drive(14'd0, 32'd0, 1'b0, 1'b0);
      s_frag_tvalid = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      reset = 1'b0;
      @(negedge aclk);
      chk("post_reset_tready", s_frag_tready, 1'b1);
      chk("post_reset_mvalid", m_frag_tvalid, 1'b0);
      @(posedge aclk);
      #1;

      send(14'd5, 32'h0000_4000, 1'b1, 1'b0, a1);
      drain();
      chk("mem5_written", bmem[5], 16'h4000);

      send(14'd5, 32'h0001_0000, 1'b1, 1'b1, a1);
      drain();
      chk("mem5_kept", bmem[5], 16'h4000);

      send(14'd7, 32'h0000_3000, 1'b1, 1'b0, a1);
      send(14'd7, 32'h0000_3000, 1'b1, 1'b1, a2);
      chk("hazard_wait", a2 - a1, RL + 2);
      drain();

      send(14'd100, {16'd0, 16'($urandom)}, 1'b1, 1'b0, prev);
      for (int i = 1; i < 6; i++) begin
         send(14'(100 + i), {16'd0, 16'($urandom)}, 1'b1, 1'(i == 5), a1);
         chk("throughput", a1 - prev, 1);
         prev = a1;
      end
      drain();

      lat_mode = 1'b0;
      m_frag_tready = 1'b0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         drive(14'(200 + k), {16'd0, 16'($urandom)}, 1'b1, 1'(k == 7));
         @(negedge aclk);
         if (s_frag_tready) begin
            predict();
            k++;
         end
         @(posedge aclk);
         #1;
      end
      s_frag_tvalid = 1'b0;
      chk("bp_accepted", k, 4);
      m_frag_tready = 1'b1;
      while (k < 8) begin
         send(14'(200 + k), {16'd0, 16'($urandom)}, 1'b1, 1'(k == 7), a1);
         k++;
      end
      drain();
      lat_mode = 1'b1;

      confEnable = 1'b0;
      for (int i = 0; i < 4; i++) send(14'd5, 32'h0002_0000 + 32'(i), 1'(i[0]), 1'(i == 3), a1);
      drain();
      confEnable = 1'b1;

      send(14'd300, 32'h0000_0100, 1'b1, 1'b0, a1);
      reset = 1'b1;
      oq.delete();
      wq.delete();
      rmem[300] = 16'h8000;
      repeat (2) @(posedge aclk);
      #1;
      reset = 1'b0;
      @(negedge aclk);
      chk("rst_mid_mvalid", m_frag_tvalid, 1'b0);
      repeat (5) @(posedge aclk);
      #1;
      chk("rst_mid_mem", bmem[300], 16'h8000);

      lat_mode = 1'b0;
      for (int b = 0; b < 8; b++) begin
         confDepthFunc = 3'(b);
         confDepthMask = 1'($urandom_range(0, 3) != 0);
         rnd_ready = 1'b1;
         for (int i = 0; i < 20; i++)
            send(14'(400 + $urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? $urandom : {16'd0, 16'($urandom_range(16'h7000, 16'h9000))},
                 1'($urandom_range(0, 4) != 0), 1'(i == 19), a1);
         rnd_ready = 1'b0;
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
